// File: rtl/i3c_hdr_mode_ctrl.sv
// rtl/i3c_hdr_mode_ctrl.sv - system-clock HDR mode sequencer behind the I3C HDR exit/restart detector
//
// Purpose:
//   Tracks ENTHDRn entry from the SDR CCC decoder and runs the HDR session
//   state machine. It resynchronizes the detector's asynchronous exit and
//   restart levels, and returns in_HDR_mode / HDR_restart_ack to the detector.
//   It also issues single-cycle exit and restart events to the HDR engines.
//
// Parameters:
//   ENA_HDR      HDR support mask (bit0 DDR, bit1 TSP, bit2 TSL); 0 disables HDR and the restart path
//   SYNC_STAGES  synchronizer depth for the raw detector levels (2..4)
//   ACK_HOLD     minimum number of CLK cycles HDR_restart_ack stays high (1..15)
//
// Ports:
//   CLK              system clock
//   RST              asynchronous active-high reset
//   ccc_enthdr       one-cycle pulse, SDR decoder accepted ENTHDRn
//   ccc_hdr_code     n of ENTHDRn, valid with ccc_enthdr
//   raw_hdr_exit     detector oHDR_exit, asynchronous level
//   raw_hdr_restart  detector oHDR_restart, asynchronous level
//   in_HDR_mode      1 while in any HDR session, including ignored modes
//   HDR_restart_ack  clears the detector's restart flag
//   hdr_mode         ENTHDR code of the current or last HDR session
//   hdr_active       1 only in a supported HDR mode (engine enable)
//   hdr_exit_evt     one-cycle pulse on an accepted exit
//   hdr_restart_evt  one-cycle pulse on an accepted restart
//   hdr_unsup        sticky, last ENTHDR code was unsupported

module i3c_hdr_mode_ctrl #(
    parameter logic [2:0] ENA_HDR     = 3'b000,
    parameter int          SYNC_STAGES = 2,
    parameter int          ACK_HOLD    = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ccc_enthdr,
    input  logic [2:0] ccc_hdr_code,
    input  logic       raw_hdr_exit,
    input  logic       raw_hdr_restart,
    output logic       in_HDR_mode,
    output logic       HDR_restart_ack,
    output logic [2:0] hdr_mode,
    output logic       hdr_active,
    output logic       hdr_exit_evt,
    output logic       hdr_restart_evt,
    output logic       hdr_unsup
);

    typedef enum logic [2:0] {
        ST_SDR    = 3'd0,
        ST_HDR    = 3'd1,
        ST_IGNORE = 3'd2,
        ST_RACK   = 3'd3,
        ST_EXIT   = 3'd4
    } state_t;

    localparam logic       HAS_HDR   = |ENA_HDR;
    localparam logic [7:0] ENA_VEC   = {5'b00000, ENA_HDR};
    localparam logic [3:0] ACK_LOAD  = 4'(ACK_HOLD);

    state_t                 state;
    logic [SYNC_STAGES-1:0] exit_sh;
    logic [SYNC_STAGES-1:0] restart_sh;
    logic                   exit_prev;
    logic                   restart_prev;
    logic                   exit_sync;
    logic                   restart_sync;
    logic                   exit_rise;
    logic                   restart_rise;
    logic                   code_ok;
    logic                   ack_q;
    logic [3:0]             ack_cnt;

    // Synchronizer chains followed by one edge flop each.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exit_sh      <= '0;
            restart_sh   <= '0;
            exit_prev    <= 1'b0;
            restart_prev <= 1'b0;
        end else begin
            exit_sh      <= {exit_sh[SYNC_STAGES-2:0], raw_hdr_exit};
            restart_sh   <= {restart_sh[SYNC_STAGES-2:0], raw_hdr_restart};
            exit_prev    <= exit_sh[SYNC_STAGES-1];
            restart_prev <= restart_sh[SYNC_STAGES-1];
        end
    end

    assign exit_sync    = exit_sh[SYNC_STAGES-1];
    assign restart_sync = restart_sh[SYNC_STAGES-1];
    assign exit_rise    = exit_sync & ~exit_prev;
    assign restart_rise = restart_sync & ~restart_prev;

    // Codes above TSL index the zero-padded upper bits and read back as unsupported.
    assign code_ok = ENA_VEC[ccc_hdr_code] & (ccc_hdr_code <= 3'd2);

    // With no HDR support the restart handshake does not exist at all.
    assign HDR_restart_ack = HAS_HDR ? ack_q : 1'b0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state           <= ST_SDR;
            in_HDR_mode     <= 1'b0;
            ack_q           <= 1'b0;
            hdr_mode        <= 3'd0;
            hdr_active      <= 1'b0;
            hdr_exit_evt    <= 1'b0;
            hdr_restart_evt <= 1'b0;
            hdr_unsup       <= 1'b0;
            ack_cnt         <= 4'd0;
        end else begin
            hdr_exit_evt    <= 1'b0;
            hdr_restart_evt <= 1'b0;

            case (state)
                ST_SDR: begin
                    in_HDR_mode <= 1'b0;
                    hdr_active  <= 1'b0;
                    ack_q       <= 1'b0;
                    // Detector edges seen here are consumed by the edge flops and never replayed.
                    if (ccc_enthdr) begin
                        hdr_mode    <= ccc_hdr_code;
                        in_HDR_mode <= 1'b1;
                        if (code_ok) begin
                            state      <= ST_HDR;
                            hdr_active <= 1'b1;
                            hdr_unsup  <= 1'b0;
                        end else begin
                            state      <= ST_IGNORE;
                            hdr_active <= 1'b0;
                            hdr_unsup  <= 1'b1;
                        end
                    end
                end

                ST_HDR: begin
                    // Exit has priority over a restart rising in the same cycle.
                    if (exit_rise) begin
                        state        <= ST_EXIT;
                        in_HDR_mode  <= 1'b0;
                        hdr_active   <= 1'b0;
                        hdr_exit_evt <= 1'b1;
                    end else if (restart_rise && HAS_HDR) begin
                        state           <= ST_RACK;
                        hdr_active      <= 1'b0;
                        ack_q           <= 1'b1;
                        hdr_restart_evt <= 1'b1;
                        ack_cnt         <= ACK_LOAD;
                    end
                end

                ST_IGNORE: begin
                    if (exit_rise) begin
                        state        <= ST_EXIT;
                        in_HDR_mode  <= 1'b0;
                        hdr_exit_evt <= 1'b1;
                    end
                end

                ST_RACK: begin
                    if (exit_rise) begin
                        state        <= ST_EXIT;
                        in_HDR_mode  <= 1'b0;
                        ack_q        <= 1'b0;
                        hdr_exit_evt <= 1'b1;
                    end else if (ack_cnt == 4'd0 && !restart_sync) begin
                        // Release only once the detector has dropped its restart level.
                        state      <= ST_HDR;
                        ack_q      <= 1'b0;
                        hdr_active <= 1'b1;
                    end else if (ack_cnt != 4'd0) begin
                        ack_cnt <= ack_cnt - 4'd1;
                    end
                end

                ST_EXIT: begin
                    // Wait for the detector to clear its exit level before accepting SDR traffic.
                    if (!exit_sync) begin
                        state <= ST_SDR;
                    end
                end

                default: begin
                    state       <= ST_SDR;
                    in_HDR_mode <= 1'b0;
                    hdr_active  <= 1'b0;
                    ack_q       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/i3c_hdr_mode_ctrl.md
Name: i3c_hdr_mode_ctrl

Overview:
System-clock HDR mode sequencer sitting directly downstream of the I3C HDR exit/restart detector. It consumes the detector's asynchronous oHDR_exit/oHDR_restart levels through synchronizers. It drives the detector's in_HDR_mode and HDR_restart_ack inputs back, and tracks ENTHDRn entry from the SDR CCC decoder. It also issues single-cycle exit/restart events to the HDR engines.

Parameters:
ENA_HDR, 3'b000, HDR support mask (bit0 DDR, bit1 TSP, bit2 TSL); 0 = no HDR, restart path disabled
SYNC_STAGES, 2, synchronizer depth for raw exit/restart inputs (legal 2..4)
ACK_HOLD, 4, minimum CLK cycles HDR_restart_ack is held high (legal 1..15)

Ports:
CLK  input  1  system clock; the only clock in this block
RST  input  1  asynchronous active-high reset
ccc_enthdr  input  1  one-cycle pulse: SDR decoder accepted ENTHDRn
ccc_hdr_code  input  3  n of ENTHDRn, valid with ccc_enthdr
raw_hdr_exit  input  1  detector oHDR_exit (async level)
raw_hdr_restart  input  1  detector oHDR_restart (async level)
in_HDR_mode  output  1  to detector and engines; 1 while in HDR (incl. ignored modes)
HDR_restart_ack  output  1  to detector; clears its restart flag
hdr_mode  output  3  latched ENTHDR code of the current/last HDR session
hdr_active  output  1  1 only in a supported HDR mode (engine enable)
hdr_exit_evt  output  1  one-cycle pulse on accepted exit
hdr_restart_evt  output  1  one-cycle pulse on accepted restart
hdr_unsup  output  1  sticky: an unsupported ENTHDR code was seen; cleared on next ENTHDR

Behaviour:
- Reset, asynchronous on RST high: every output 0; state SDR; synchronizers and edge flops 0; ack counter 0.
- Sync: each raw input passes SYNC_STAGES flops, then one edge flop. A rise is sync=1 & prev=0. Raw edge to event pulse is SYNC_STAGES+1 cycles.
- States: SDR, HDR, IGNORE, RACK, EXIT.
- SDR: outputs low. On ccc_enthdr: latch hdr_mode=ccc_hdr_code.
  - Code<=2 and ENA_HDR[code]=1: go to HDR, clear hdr_unsup.
  - Otherwise: go to IGNORE, set hdr_unsup.
  - Exit/restart rises in SDR are ignored and produce no events.
- HDR: in_HDR_mode=1, hdr_active=1.
  - Exit rise: go to EXIT, pulse hdr_exit_evt.
  - Else restart rise, only when ENA_HDR!=0: go to RACK, pulse hdr_restart_evt, load counter=ACK_HOLD.
- IGNORE: in_HDR_mode=1, hdr_active=0.
  - Exit rise: go to EXIT, pulse hdr_exit_evt.
  - Restart is ignored.
- RACK: in_HDR_mode=1, hdr_active=0, HDR_restart_ack=1. Counter decrements each cycle.
  - Counter=0 and synchronized restart=0: go to HDR, drop ack on the same edge.
  - Exit rise in RACK: go to EXIT, drop ack, pulse hdr_exit_evt. No return to HDR.
- EXIT: in_HDR_mode=0, hdr_active=0.
  - Wait for synchronized exit=0 (SCL high has cleared the detector), then go to SDR.
  - Exit/restart edges in EXIT are ignored. Minimum dwell is 1 cycle.
- Simultaneous exit rise and restart rise in one cycle: exit wins, no restart event.
- ccc_enthdr outside SDR is ignored; hdr_mode is unchanged.
- ccc_enthdr in the same cycle as an exit rise while in SDR: entry is taken and the exit edge is dropped.
- hdr_mode holds after exit until the next ENTHDR.
- Events are exactly one cycle wide; at most one event per cycle.
- ENA_HDR=0: RACK is unreachable, HDR_restart_ack is tied 0, and every ENTHDR goes to IGNORE.
- RST asserted mid-session: immediate return to SDR, all outputs 0. This deasserts in_HDR_mode and so resets the detector's restart logic.

Test Plan:
- ENA_HDR=3'b001, ENTHDR code 0, then raw_hdr_exit high 10 cycles -> in_HDR_mode=1, hdr_active=1. hdr_exit_evt pulses once at SYNC_STAGES+1=3 cycles after the exit rise. State is EXIT until exit drops, then SDR with in_HDR_mode=0 and hdr_mode=0.
- ENA_HDR=3'b001, code 0, raw_hdr_restart pulse (high until ack) -> hdr_restart_evt at +3. HDR_restart_ack high >=4 cycles and until synchronized restart is low, then back to HDR with hdr_active=1.
- ENA_HDR=3'b001, ENTHDR code 1 -> hdr_unsup=1, in_HDR_mode=1, hdr_active=0. A restart pulse gives no event and no ack. An exit gives hdr_exit_evt, then SDR.
- Code 0 session, exit and restart rise in the same CLK edge -> only hdr_exit_evt, HDR_restart_ack stays 0, state EXIT. Also: exit during RACK -> ack drops, exit event, EXIT.
- ENA_HDR=0, ENTHDR code 0 plus restart pulse -> IGNORE, HDR_restart_ack never 1, no restart event.
- RST pulse while in RACK with ack high -> all outputs 0 asynchronously. A later ENTHDR code 0 re-enters HDR normally. ccc_enthdr while in HDR leaves hdr_mode unchanged.
